// File: rtl/pipe_adder_pkg.sv
// Shared configuration helpers for the segmented, pipelined add/subtract unit.
package pipe_adder_pkg;

   localparam int unsigned DEF_WIDTH  = 32;
   localparam int unsigned DEF_STAGES = 4;

   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

   function automatic int unsigned seg_width(input int unsigned width,
                                             input int unsigned stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit adder slice; one instance resolves one pipeline stage.
module adder_segment #(
   parameter int unsigned SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract: one carry segment per stage, valid/ready per stage.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SEG = seg_width(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   // a/b hold operand bits still to be resolved, s holds resolved result bits.
   typedef struct packed {
      logic             valid;
      logic             sub;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
      logic             carry;
      logic             a_msb;
      logic             b_msb;
   } stage_t;

   stage_t        stq [STAGES];
   stage_t        src [STAGES];
   logic [STAGES:0] rdy;

   assign rdy[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t          q;
      logic [SEG-1:0]  seg_sum;
      logic            seg_c;

      if (k == 0) begin : g_src_in
         logic [WIDTH-1:0] b_eff;
         assign b_eff  = sub ? ~b : b;
         assign src[k] = '{valid: in_valid, sub: sub, a: a, b: b_eff, s: '0,
                           carry: sub ? ~cin : cin, a_msb: a[WIDTH-1],
                           b_msb: b_eff[WIDTH-1]};
      end else begin : g_src_prev
         assign src[k] = stq[k-1];
      end

      // A stage reloads whenever it is empty or its content moves on, so bubbles collapse.
      assign rdy[k] = ~q.valid | rdy[k+1];

      adder_segment #(
         .SEG(SEG)
      ) u_seg (
         .a   (src[k].a[k*SEG +: SEG]),
         .b   (src[k].b[k*SEG +: SEG]),
         .cin (src[k].carry),
         .sum (seg_sum),
         .cout(seg_c)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (rdy[k]) begin
            q                 <= src[k];
            q.s[k*SEG +: SEG] <= seg_sum;
            q.carry           <= seg_c;
         end
      end

      assign stq[k] = q;
   end

   stage_t last;
   assign last = stq[STAGES-1];

   assign in_ready  = rdy[0];
   assign out_valid = last.valid;
   assign sum       = last.s;
   assign cout      = last.sub ^ last.carry;
   assign ovf       = (last.a_msb == last.b_msb) & (last.s[WIDTH-1] != last.a_msb);

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: arithmetic reference model with an in-order result scoreboard.
module tb_pipe_adder;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  a = '0;
   logic [WIDTH-1:0]  b = '0;
   logic              cin = 1'b0;
   logic              sub = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic              ovf;

   always #5 clk = ~clk;

   pipe_adder #(
      .WIDTH (WIDTH),
      .STAGES(STAGES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
   );

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        c;
      logic        v;
   } vec_t;

   res_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   logic held = 1'b0;
   logic [33:0] held_val = '0;
   logic saw_full = 1'b0;

   // Reference: plain unsigned arithmetic on 33-bit values.
   function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic sb);
      res_t        r;
      logic [32:0] t;
      if (!sb) begin
         t   = {1'b0, x} + {1'b0, y} + 33'(ci);
         r.s = t[31:0];
         r.c = t[32];
         r.v = (x[31] == y[31]) && (r.s[31] != x[31]);
      end else begin
         t   = {1'b0, x} - {1'b0, y} - 33'(ci);
         r.s = t[31:0];
         r.c = ({1'b0, x} < ({1'b0, y} + 33'(ci)));
         r.v = (x[31] != y[31]) && (r.s[31] != x[31]);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
      end
   endtask

   // Single compare process: scoreboard, in_ready occupancy rule, stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
         exp_q.delete();
      end else begin
         check("in_ready_vs_occupancy", 64'(in_ready),
               64'((exp_q.size() < STAGES) || out_ready));
         if (!in_ready) saw_full = 1'b1;
         if (held) begin
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_stable", 64'({sum, cout, ovf}), 64'(held_val));
         end
         held     = out_valid && !out_ready;
         held_val = {sum, cout, ovf};
         if (out_valid && out_ready) begin
            check("result_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               res_t e;
               e = exp_q.pop_front();
               check("sum", 64'(sum), 64'(e.s));
               check("cout", 64'(cout), 64'(e.c));
               check("ovf", 64'(ovf), 64'(e.v));
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic sb);
      bit acc;
      acc      = 1'b0;
      a        = x;
      b        = y;
      cin      = ci;
      sub      = sb;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   vec_t vecs [6];
   int   lat;

   initial begin
      vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'h1, cin: 0, sub: 0, s: 32'h0, c: 1, v: 0};
      vecs[1] = '{a: 32'h7FFF_FFFF, b: 32'h1, cin: 0, sub: 0, s: 32'h8000_0000, c: 0, v: 1};
      vecs[2] = '{a: 32'h5, b: 32'h7, cin: 0, sub: 1, s: 32'hFFFF_FFFE, c: 1, v: 0};
      vecs[3] = '{a: 32'h7, b: 32'h5, cin: 1, sub: 1, s: 32'h1, c: 0, v: 0};
      vecs[4] = '{a: 32'h8000_0000, b: 32'h1, cin: 0, sub: 1, s: 32'h7FFF_FFFF, c: 0, v: 1};
      vecs[5] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, cin: 1, sub: 0, s: 32'hFFFF_FFFF,
                  c: 1, v: 0};

      // Reset held with input traffic offered.
      #1 rst_n = 1'b0;
      in_valid = 1'b1;
      a        = 32'h1234_5678;
      b        = 32'h1;
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", 64'(out_valid), 64'(0));
         check("rst_sum", 64'(sum), 64'(0));
         check("rst_cout_ovf", 64'({cout, ovf}), 64'(0));
         check("rst_in_ready", 64'(in_ready), 64'(1));
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      rst_n = 1'b1;

      // First-result latency.
      @(posedge clk);
      #1;
      a        = 32'h1;
      b        = 32'h2;
      cin      = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", 64'(lat), 64'(STAGES));
      drain();

      // Directed vectors; model pinned against hand values first.
      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         res_t r;
         r = model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         check("model_pin", 64'({r.s, r.c, r.v}), 64'({vecs[i].s, vecs[i].c, vecs[i].v}));
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      end
      drain();

      // Back-to-back random beats with a 10-cycle output stall mid-stream.
      saw_full = 1'b0;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 20; i++)
               send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         begin
            repeat (8) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("in_ready_fell_when_full", 64'(saw_full), 64'(1));

      // Reset with three beats in flight, oldest parked at the output.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(32'hDEAD_0001, 32'h1, 1'b0, 1'b0);
      send(32'hDEAD_0002, 32'h1, 1'b0, 1'b0);
      send(32'hDEAD_0003, 32'h1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("pre_reset_out_valid", 64'(out_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_sum", 64'(sum), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
      send(32'hC000_0000, 32'hC000_0000, 1'b0, 1'b0);
      drain();
      repeat (10) begin
         @(negedge clk);
         check("no_stale_output", 64'(out_valid), 64'(0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
